prefetch_buffer: RTL and testbench
==================================

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

Interface
REQ-001 SHALL have parameter depth, default prefetch_depth (4), number of buffered instruction words; power of two, >=2.
REQ-002 SHALL have parameter start_addr, default start_base_addr (32'h0), first prefetch address after reset.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port fetch_valid  in  1  core requests instruction at fetch_addr.
REQ-006 SHALL have port fetch_addr  in  32  requested address; bits [1:0] ignored.
REQ-007 SHALL have port fetch_ready  out  1  fetch_rdata holds the word at fetch_addr this cycle.
REQ-008 SHALL have port fetch_rdata  out  32  instruction word.
REQ-009 SHALL have port mem_valid  out  1  read request to BRAM.
REQ-010 SHALL have port mem_addr  out  32  word-aligned read address, [1:0]=0.
REQ-011 SHALL have port mem_ready  in  1  memory accepted request and mem_rdata is valid this cycle.
REQ-012 SHALL have port mem_rdata  in  32  read data.

Function
REQ-013 SHALL hold a circular buffer of depth words plus head_addr (address of oldest entry), fill_addr (next address to request) and count (0..depth).
REQ-014 SHALL assert fetch_ready combinationally when fetch_valid, count>0 and fetch_addr[31:2]==head_addr[31:2]; fetch_rdata = head entry.
REQ-015 On a hit, SHALL pop the head: head_addr += 4, count -= 1 at next edge.
REQ-016 On fetch_valid and miss, SHALL redirect: count=0, head_addr=fill_addr={fetch_addr[31:2],2'b00} at next edge; fetch_ready=0 that cycle.
REQ-017 SHALL keep at most one outstanding memory request; mem_valid and mem_addr held stable until mem_ready.
REQ-018 SHALL issue a request (mem_valid=1, mem_addr=fill_addr) in FETCH whenever count + outstanding < depth.
REQ-019 On mem_ready in FETCH, SHALL write mem_rdata at tail, count += 1, fill_addr += 4; data visible on fetch side the following cycle.
REQ-020 Simultaneous pop and push SHALL leave count unchanged; push never overflows because of REQ-018.
REQ-021 SHALL implement states IDLE (after reset, one cycle), FETCH (normal), DROP (redirect while a request is outstanding).
REQ-022 Transitions: IDLE->FETCH unconditionally; FETCH->DROP on miss with outstanding request lacking mem_ready that cycle; DROP->FETCH on mem_ready, data discarded, no count change.
REQ-023 A miss coinciding with mem_ready SHALL discard that data and go directly to FETCH.
REQ-024 fill_addr and head_addr SHALL wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-025 Redirect-to-first-data latency SHALL be 1 cycle plus memory latency (bram_latency) plus 1 cycle, excluding DROP time.

Reset
REQ-026 On reset low: state=IDLE, count=0, head_addr=fill_addr=start_addr, outstanding=0, mem_valid=0, mem_addr=start_addr, fetch_ready=0, fetch_rdata=0.
REQ-027 Reset mid-request SHALL abandon the outstanding request; memory is reset together with this block.

Configuration
REQ-028 Macro PREFETCH_BYPASS_EN: when defined, mem_ready with count==0 and fetch_valid and fetch_addr[31:2]==mem_addr[31:2] in FETCH SHALL drive fetch_ready=1, fetch_rdata=mem_rdata same cycle, word not stored, fill_addr += 4, head_addr += 4.
REQ-029 Without PREFETCH_BYPASS_EN, returned data SHALL always go through the buffer (REQ-019).

Structure
REQ-030 The shared configure package SHALL carry prefetch_depth and start_base_addr; a prefetch_state_t enum (IDLE, FETCH, DROP) SHALL be added to the shared package.
REQ-031 Storage SHALL be a sub-module prefetch_fifo (depth words, write/read pointers, no reset of data array).

Verification
REQ-032 Reset release, mem_ready every cycle, fetch 0x0,0x4,0x8 -> mem_addr sequence 0x0,0x4,0x8,0xC; fetch_ready on each hit with matching data.
REQ-033 No fetch_valid, zero-latency memory -> exactly 4 requests (0x0..0xC) then mem_valid=0, count=4.
REQ-034 Fetch 0x100 while request to 0x10 outstanding and mem_ready delayed 3 cycles -> DROP, 0x10 data discarded, next mem_addr=0x100, first fetch_ready for 0x100 with its data.
REQ-035 Full buffer, pop and mem_ready same cycle -> count stays 4, order preserved.
REQ-036 Redirect to 0xFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-037 With PREFETCH_BYPASS_EN, empty buffer, fetch 0x20 and mem_ready for 0x20 -> fetch_ready same cycle; without it, one cycle later.

Source files
------------

// File: rtl/prefetch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// prefetch_buffer_pkg
// Shared configuration for the instruction prefetch buffer: default buffer
// depth, default first prefetch address, and the controller state type.
// No ports (package).
// -----------------------------------------------------------------------------
package prefetch_buffer_pkg;

  // Number of buffered instruction words (power of two, >= 2).
  localparam int prefetch_depth = 4;

  // First address prefetched after reset.
  localparam logic [31:0] start_base_addr = 32'h0000_0000;

  // IDLE  : single cycle after reset before prefetching starts
  // FETCH : normal operation, requests issued while there is room
  // DROP  : redirect happened while a read was in flight; wait for it and
  //         throw its data away
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } prefetch_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
// Word storage for the prefetch buffer: a circular array of depth entries
// with write and read pointers. The data array itself is never reset; the
// owner tracks occupancy and only looks at rd_data when an entry is valid.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (pointers only)
//   flush    in   discard all entries (pointers back to 0)
//   wr_en    in   write wr_data at the tail
//   wr_data  in   word to store
//   rd_en    in   drop the head entry
//   rd_data  out  head entry (combinational from the read pointer)
// -----------------------------------------------------------------------------
module prefetch_fifo #(
  parameter int depth = 4,
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [width-1:0] rd_data
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem_reg [depth];
  logic [aw-1:0]    wr_ptr_reg;
  logic [aw-1:0]    rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  // depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Same-cycle read of the head: the core sees a stored word one cycle after
  // it was written.
  assign rd_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/prefetch_buffer.sv
// -----------------------------------------------------------------------------
// prefetch_buffer
// Sequential instruction prefetcher between a core fetch port and a BRAM
// read port. Keeps up to depth consecutive words ahead of the core, pops on
// a hit, and restarts from the requested address on a miss. At most one
// memory read is in flight; a redirect during an in-flight read waits in
// DROP for that read and discards it.
//
// Optional feature (macro PREFETCH_BYPASS_EN): with an empty buffer, a read
// returning the exact word the core is asking for is forwarded to the core
// in the same cycle instead of being stored.
//
// Parameters
//   depth       buffered words (power of two, >= 2)
//   start_addr  first prefetch address after reset
//
// Ports
//   clock        in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   fetch_valid  in   core requests the word at fetch_addr
//   fetch_addr   in   requested byte address, bits [1:0] ignored
//   fetch_ready  out  fetch_rdata holds the word at fetch_addr this cycle
//   fetch_rdata  out  instruction word
//   mem_valid    out  read request to memory
//   mem_addr     out  word-aligned read address
//   mem_ready    in   memory accepted the request, mem_rdata valid
//   mem_rdata    in   read data
// -----------------------------------------------------------------------------
module prefetch_buffer
  import prefetch_buffer_pkg::*;
#(
  parameter int          depth      = prefetch_depth,
  parameter logic [31:0] start_addr = start_base_addr
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int             cw         = $clog2(depth) + 1;
  localparam logic [cw-1:0]  depth_c    = cw'(depth);
  localparam logic [29:0]    start_word = start_addr[31:2];

  // Addresses are kept as 30-bit word addresses; incrementing by one word
  // therefore wraps modulo 2^32 in byte terms.
  prefetch_state_t state_reg, state_next;
  logic [cw-1:0]   count_reg, count_next;
  logic [29:0]     head_word_reg, head_word_next;
  logic [29:0]     fill_word_reg, fill_word_next;
  logic [29:0]     drop_word_reg, drop_word_next;

  logic [29:0] fetch_word;
  logic        unused_addr_bits;
  logic        addr_match;
  logic        miss;
  logic        hit;
  logic        bypass;
  logic        push;
  logic        flush;
  logic [31:0] head_data;

  assign fetch_word       = fetch_addr[31:2];
  assign unused_addr_bits = ^fetch_addr[1:0];

  // A miss is an address mismatch. Asking for the head address while the
  // buffer is still empty simply waits for the data already on its way.
  assign addr_match = (fetch_word == head_word_reg);
  assign miss       = fetch_valid && !addr_match;
  assign hit        = fetch_valid && addr_match && (count_reg != '0);

  // In FETCH, room in the buffer means a request is (or stays) outstanding;
  // count < depth is count + outstanding < depth with one request at most.
  // DROP keeps the abandoned request on the bus until memory completes it.
  assign mem_valid = ((state_reg == FETCH) && (count_reg < depth_c)) ||
                     (state_reg == DROP);
  assign mem_addr  = {(state_reg == DROP) ? drop_word_reg : fill_word_reg, 2'b00};

`ifdef PREFETCH_BYPASS_EN
  // Empty buffer in FETCH means head == fill == mem_addr.
  assign bypass = (state_reg == FETCH) && (count_reg == '0) && mem_ready &&
                  fetch_valid && (fetch_word == fill_word_reg);
`else
  assign bypass = 1'b0;
`endif

  // Returning data is discarded on a miss in the same cycle.
  assign push  = (state_reg == FETCH) && mem_valid && mem_ready && !miss && !bypass;
  assign flush = miss && (state_reg == FETCH);

  assign fetch_ready = hit || bypass;
  assign fetch_rdata = bypass ? mem_rdata : ((count_reg != '0) ? head_data : 32'h0);

  prefetch_fifo #(
    .depth (depth),
    .width (32)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (mem_rdata),
    .rd_en   (hit),
    .rd_data (head_data)
  );

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    head_word_next = head_word_reg;
    fill_word_next = fill_word_reg;
    drop_word_next = drop_word_reg;

    unique case (state_reg)
      IDLE: begin
        state_next = FETCH;
        if (miss) begin
          head_word_next = fetch_word;
          fill_word_next = fetch_word;
        end
      end

      FETCH: begin
        if (miss) begin
          count_next     = '0;
          head_word_next = fetch_word;
          fill_word_next = fetch_word;
          // Read still in flight: remember its address and wait it out.
          if (mem_valid && !mem_ready) begin
            state_next     = DROP;
            drop_word_next = fill_word_reg;
          end
        end else begin
          if (hit || bypass) head_word_next = head_word_reg + 30'd1;
          if (push || bypass) fill_word_next = fill_word_reg + 30'd1;
          case ({push, hit})
            2'b10:   count_next = count_reg + cw'(1);
            2'b01:   count_next = count_reg - cw'(1);
            default: count_next = count_reg;
          endcase
        end
      end

      DROP: begin
        // Buffer is empty here; a new miss just retargets the restart point.
        if (miss) begin
          head_word_next = fetch_word;
          fill_word_next = fetch_word;
        end
        if (mem_ready) state_next = FETCH;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      head_word_reg <= start_word;
      fill_word_reg <= start_word;
      drop_word_reg <= start_word;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      head_word_reg <= head_word_next;
      fill_word_reg <= fill_word_next;
      drop_word_reg <= drop_word_next;
    end
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_prefetch_buffer
// Directed scenarios plus a randomized run of prefetch_buffer against a
// queue-based model of the buffer contents and a memory whose word at each
// address is a fixed function of that address.
// -----------------------------------------------------------------------------
module tb_prefetch_buffer;

  localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] fetch_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clock = ~clock;

  prefetch_buffer #(
    .depth      (DEPTH),
    .start_addr (32'h0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_rdata (fetch_rdata),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'hA5A5_1234;
  endfunction

  // Model: words held in the buffer (by address), restart point, drop state.
  logic [31:0] m_q[$];
  logic [31:0] m_head, m_fill, m_drop_addr;
  bit          m_idle, m_drop;

  // Memory responder.
  int wcnt, lat_cur, lat_min, lat_max;

  // Observation log.
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  int          cyc, hits, first_ready_cyc;
  bit          last_ready;

  function automatic logic [31:0] log_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic apply_reset();
    reset       = 1'b0;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0;
    mem_ready   = 1'b0;
    mem_rdata   = 32'h0;
    #1;
    check_eq("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_fetch_ready", {31'b0, fetch_ready}, 32'h0);
    check_eq("rst_fetch_rdata", fetch_rdata, 32'h0);
    @(posedge clock);
    #1;
    fetch_valid = 1'b0;
    reset = 1'b1;
    m_q.delete();
    m_head = 32'h0; m_fill = 32'h0; m_drop_addr = 32'h0;
    m_idle = 1'b1;  m_drop = 1'b0;
    wcnt = 0; lat_cur = 0;
    acc_log.delete(); acc_cyc.delete();
    cyc = 0; hits = 0; first_ready_cyc = -1; last_ready = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit fv, input logic [31:0] fa);
    logic [31:0] fa_al, e_ma;
    bit mr, e_mv, e_match, e_miss, e_hit, e_byp, e_rdy;
    fa_al = {fa[31:2], 2'b00};
    if (!mem_valid) begin
      wcnt = 0;
      mr   = 1'b0;
    end else begin
      if (wcnt == 0) lat_cur = $urandom_range(lat_min, lat_max);
      if (wcnt >= lat_cur) begin
        mr   = 1'b1;
        wcnt = 0;
      end else begin
        mr = 1'b0;
        wcnt++;
      end
    end
    mem_ready   = mr;
    mem_rdata   = mr ? memfn(mem_addr) : $urandom;
    fetch_valid = fv;
    fetch_addr  = {fa[31:2], 2'($urandom_range(0, 3))};
    #1;
    e_mv    = !m_idle && (m_drop || (m_q.size() < DEPTH));
    e_ma    = m_drop ? m_drop_addr : m_fill;
    e_match = (fa_al == m_head);
    e_miss  = fv && !e_match;
    e_hit   = fv && e_match && (m_q.size() > 0);
    e_byp   = BYP && !m_idle && !m_drop && (m_q.size() == 0) && mr && fv && (fa_al == m_fill);
    e_rdy   = e_hit || e_byp;
    check_eq("mem_valid", {31'b0, mem_valid}, {31'b0, e_mv});
    if (e_mv) check_eq("mem_addr", mem_addr, e_ma);
    check_eq("fetch_ready", {31'b0, fetch_ready}, {31'b0, e_rdy});
    if (e_rdy) check_eq("fetch_rdata", fetch_rdata, memfn(fa_al));
    if (mem_valid && mr) begin
      acc_log.push_back(mem_addr);
      acc_cyc.push_back(cyc);
      $display("[%0d] mem read  addr=%h data=%h", cyc, mem_addr, mem_rdata);
    end
    last_ready = fetch_ready;
    if (fetch_ready) begin
      hits++;
      if (first_ready_cyc < 0) first_ready_cyc = cyc;
      $display("[%0d] fetch hit addr=%h data=%h", cyc, fa_al, fetch_rdata);
    end
    if (m_idle) begin
      m_idle = 1'b0;
      if (e_miss) begin m_head = fa_al; m_fill = fa_al; end
    end else if (m_drop) begin
      if (e_miss) begin m_head = fa_al; m_fill = fa_al; end
      if (mr) m_drop = 1'b0;
    end else if (e_miss) begin
      m_q.delete();
      if (e_mv && !mr) begin m_drop = 1'b1; m_drop_addr = m_fill; end
      m_head = fa_al;
      m_fill = fa_al;
    end else begin
      if (e_hit) begin void'(m_q.pop_front()); m_head = m_head + 32'd4; end
      if (e_byp) begin
        m_head = m_head + 32'd4;
        m_fill = m_fill + 32'd4;
      end else if (e_mv && mr) begin
        m_q.push_back(m_fill);
        m_fill = m_fill + 32'd4;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] pc;
    int guard, base;

    // A: sequential fetch 0x0, 0x4, 0x8 with single-cycle memory.
    apply_reset();
    lat_min = 0; lat_max = 0;
    pc = 32'h0; guard = 0;
    while ((hits < 3 || acc_log.size() < 4) && guard < 40) begin
      step(1'b1, pc);
      if (last_ready) pc = pc + 32'd4;
      guard++;
    end
    check_eq("a_hits", hits, BYP ? 32'd4 : 32'd3);
    check_eq("a_req0", log_at(0), 32'h0);
    check_eq("a_req1", log_at(1), 32'h4);
    check_eq("a_req2", log_at(2), 32'h8);
    check_eq("a_req3", log_at(3), 32'hC);

    // B: no fetches, buffer fills with exactly four words and stops.
    apply_reset();
    lat_min = 0; lat_max = 0;
    repeat (12) step(1'b0, 32'h0);
    check_eq("b_nreq", acc_log.size(), 32'd4);
    check_eq("b_req3", log_at(3), 32'hC);
    check_eq("b_idle_bus", {31'b0, mem_valid}, 32'h0);

    // C: redirect to 0x100 while the read of 0x10 is stalled.
    lat_min = 3; lat_max = 3;
    step(1'b1, 32'h0);
    base = acc_log.size();
    step(1'b1, 32'h100);
    first_ready_cyc = -1; guard = 0;
    while (first_ready_cyc < 0 && guard < 30) begin
      step(1'b1, 32'h100);
      guard++;
    end
    check_eq("c_got_ready", {31'b0, first_ready_cyc >= 0}, 32'h1);
    check_eq("c_dropped_req", log_at(base), 32'h10);
    check_eq("c_restart_req", log_at(base + 1), 32'h100);

    // D: full buffer, then a pop every cycle with refills alongside.
    apply_reset();
    lat_min = 0; lat_max = 0;
    repeat (8) step(1'b0, 32'h0);
    check_eq("d_full", {31'b0, mem_valid}, 32'h0);
    hits = 0; pc = 32'h0;
    repeat (10) begin
      step(1'b1, pc);
      if (last_ready) pc = pc + 32'd4;
    end
    check_eq("d_hits", hits, 32'd10);

    // E: redirect near the top of the address space wraps to zero.
    apply_reset();
    lat_min = 0; lat_max = 2;
    step(1'b1, 32'hFFFF_FFF8);
    repeat (20) step(1'b0, 32'h0);
    check_eq("e_req0", log_at(0), 32'hFFFF_FFF8);
    check_eq("e_req1", log_at(1), 32'hFFFF_FFFC);
    check_eq("e_req2", log_at(2), 32'h0);
    check_eq("e_req3", log_at(3), 32'h4);

    // F: empty buffer, core waits on 0x20; delivery relative to the read.
    apply_reset();
    lat_min = 2; lat_max = 2;
    guard = 0;
    while (first_ready_cyc < 0 && guard < 20) begin
      step(1'b1, 32'h20);
      guard++;
    end
    check_eq("f_req0", log_at(0), 32'h20);
    check_eq("f_delay", (acc_cyc.size() > 0) ? (first_ready_cyc - acc_cyc[0]) : -1,
             BYP ? 32'd0 : 32'd1);

    // G: randomized core with jumps, variable memory latency, random resets.
    apply_reset();
    pc = 32'h0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) begin
        lat_min = 0;
        lat_max = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
        pc = 32'h0;
      end
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       pc = 32'h0;
          1:       pc = 32'h100;
          2:       pc = 32'hFFFF_FFF0 + 32'd4 * 32'($urandom_range(0, 3));
          default: pc = $urandom;
        endcase
      end
      step($urandom_range(0, 3) != 0, pc);
      if (last_ready) pc = pc + 32'd4;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
